dihedral_scheduler: RTL

DIHEDRAL_SCHEDULER -- requirements
Module: dihedral_scheduler

---
 rtl/dihedral_pkg.sv | 26 ++
 rtl/dihedral_scheduler_if.sv | 50 +++++
 rtl/dihedral_wb_mux.sv | 26 ++
 rtl/dihedral_scheduler.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/dihedral_pkg.sv
// Shared types and constants for the dihedral scheduler: FSM encoding, Q16.16 coordinate width,
// and atom-slot indices.
package dihedral_pkg;

    localparam int unsigned CoordW = 32;
    localparam int unsigned XyzW   = 3 * CoordW;

    localparam logic [1:0] AtomA = 2'd0;
    localparam logic [1:0] AtomB = 2'd1;
    localparam logic [1:0] AtomC = 2'd2;
    localparam logic [1:0] AtomD = 2'd3;

    typedef enum logic [3:0] {
        StIdle,
        StTtRd,
        StTtLat,
        StCmRd,
        StCmLat,
        StLaunch,
        StWait,
        StWb,
        StNext,
        StDone
    } state_t;

endpackage

// File: rtl/dihedral_scheduler_if.sv
// Bus bundle between the dihedral scheduler (master) and its memories, force core, write-back
// sink and control (slave).
interface dihedral_scheduler_if #(
    parameter int unsigned AW = 8,
    parameter int unsigned IW = 10
) ();
    import dihedral_pkg::*;

    logic                  go;
    logic [AW:0]           n_torsions;
    logic                  tt_rd;
    logic [AW-1:0]         tt_addr;
    logic [4*IW-1:0]       tt_data;     // {d,c,b,a}
    logic                  cm_rd;
    logic [IW-1:0]         cm_addr;
    logic [XyzW-1:0]       cm_data;     // {z,y,x}
    logic                  core_start;
    logic [CoordW-1:0]     core_xa, core_ya, core_za;
    logic [CoordW-1:0]     core_xb, core_yb, core_zb;
    logic [CoordW-1:0]     core_xc, core_yc, core_zc;
    logic [CoordW-1:0]     core_xd, core_yd, core_zd;
    logic                  core_valid;
    logic                  core_busy;
    logic [4*XyzW-1:0]     core_f;      // {fa,fb,fc,fd}, each {fz,fy,fx}
    logic                  wb_valid;
    logic                  wb_ready;
    logic [IW-1:0]         wb_atom;
    logic [CoordW-1:0]     wb_fx, wb_fy, wb_fz;
    logic                  busy;
    logic                  done;
    logic                  err;
    logic [AW-1:0]         tors_idx;

    modport master (
        input  go, n_torsions, tt_data, cm_data, core_valid, core_busy, core_f, wb_ready,
        output tt_rd, tt_addr, cm_rd, cm_addr, core_start,
        output core_xa, core_ya, core_za, core_xb, core_yb, core_zb,
        output core_xc, core_yc, core_zc, core_xd, core_yd, core_zd,
        output wb_valid, wb_atom, wb_fx, wb_fy, wb_fz, busy, done, err, tors_idx
    );

    modport slave (
        output go, n_torsions, tt_data, cm_data, core_valid, core_busy, core_f, wb_ready,
        input  tt_rd, tt_addr, cm_rd, cm_addr, core_start,
        input  core_xa, core_ya, core_za, core_xb, core_yb, core_zb,
        input  core_xc, core_yc, core_zc, core_xd, core_yd, core_zd,
        input  wb_valid, wb_atom, wb_fx, wb_fy, wb_fz, busy, done, err, tors_idx
    );

endinterface

// File: rtl/dihedral_wb_mux.sv
// Selects the atom index and force vector of slot i_sel from the latched banks for write-back.
module dihedral_wb_mux
    import dihedral_pkg::*;
#(
    parameter int unsigned IW = 10
) (
    input  logic [1:0]                i_sel,
    input  logic [3:0][IW-1:0]        i_atoms,
    input  logic [3:0][XyzW-1:0]      i_forces,
    output logic [IW-1:0]             o_atom,
    output logic [CoordW-1:0]         o_fx,
    output logic [CoordW-1:0]         o_fy,
    output logic [CoordW-1:0]         o_fz
);

    logic [XyzW-1:0] w_force;

    always_comb begin
        w_force = i_forces[i_sel];
        o_atom  = i_atoms[i_sel];
        o_fx    = w_force[0*CoordW +: CoordW];
        o_fy    = w_force[1*CoordW +: CoordW];
        o_fz    = w_force[2*CoordW +: CoordW];
    end

endmodule

// File: rtl/dihedral_scheduler.sv
// Sweeps the torsion table, gathers four atom coordinates per torsion, launches the force core
// and writes back its four forces. Optional core watchdog: DIHEDRAL_SCHED_WATCHDOG_EN.
module dihedral_scheduler
    import dihedral_pkg::*;
#(
    parameter int unsigned AW       = 8,
    parameter int unsigned IW       = 10,
    parameter int unsigned WD_LIMIT = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    dihedral_scheduler_if.master bus
);

    state_t                r_state;
    logic [AW:0]           r_n;
    logic [AW-1:0]         r_tors_idx;
    logic [1:0]            r_k;
    logic [3:0][IW-1:0]    r_atoms;
    logic [3:0][XyzW-1:0]  r_coord;
    logic [3:0][XyzW-1:0]  r_force;
    logic                  r_tt_rd;
    logic [AW-1:0]         r_tt_addr;
    logic                  r_cm_rd;
    logic [IW-1:0]         r_cm_addr;
    logic                  r_core_start;
    logic                  r_wb_valid;
    logic                  r_busy;
    logic                  r_done;

    logic [AW-1:0]         w_tors_next;
    logic [AW:0]           w_tors_next_ext;

    assign w_tors_next     = r_tors_idx + 1'b1;
    assign w_tors_next_ext = {1'b0, r_tors_idx} + 1'b1;

`ifdef DIHEDRAL_SCHED_WATCHDOG_EN
    localparam int unsigned WdW = (WD_LIMIT < 2) ? 1 : $clog2(WD_LIMIT + 1);
    logic [WdW-1:0] r_wd;
    logic           r_err;
    assign bus.err = r_err;
`else
    logic w_unused_wd;
    assign w_unused_wd = (WD_LIMIT != 0);
    assign bus.err     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= StIdle;
            r_n          <= '0;
            r_tors_idx   <= '0;
            r_k          <= '0;
            r_atoms      <= '0;
            r_coord      <= '0;
            r_force      <= '0;
            r_tt_rd      <= 1'b0;
            r_tt_addr    <= '0;
            r_cm_rd      <= 1'b0;
            r_cm_addr    <= '0;
            r_core_start <= 1'b0;
            r_wb_valid   <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
`ifdef DIHEDRAL_SCHED_WATCHDOG_EN
            r_wd         <= '0;
            r_err        <= 1'b0;
`endif
        end else begin
            // Read strobes are raised on entry so they are high during their own state.
            r_tt_rd      <= 1'b0;
            r_cm_rd      <= 1'b0;
            r_core_start <= 1'b0;
            r_done       <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (bus.go) begin
                        r_n        <= bus.n_torsions;
                        r_tors_idx <= '0;
                        r_busy     <= 1'b1;
                        if (bus.n_torsions == '0) begin
                            r_state <= StDone;
                        end else begin
                            r_tt_rd   <= 1'b1;
                            r_tt_addr <= '0;
                            r_state   <= StTtRd;
                        end
                    end
                end
                StTtRd: r_state <= StTtLat;
                StTtLat: begin
                    for (int s = 0; s < 4; s++) r_atoms[s] <= bus.tt_data[s*IW +: IW];
                    r_k       <= AtomA;
                    r_cm_rd   <= 1'b1;
                    r_cm_addr <= bus.tt_data[0 +: IW];
                    r_state   <= StCmRd;
                end
                StCmRd: r_state <= StCmLat;
                StCmLat: begin
                    r_coord[r_k] <= bus.cm_data;
                    if (r_k == AtomD) begin
                        r_state <= StLaunch;
                    end else begin
                        r_k       <= r_k + 2'd1;
                        r_cm_rd   <= 1'b1;
                        r_cm_addr <= r_atoms[r_k + 2'd1];
                        r_state   <= StCmRd;
                    end
                end
                StLaunch: begin
                    if (!bus.core_busy) begin
                        r_core_start <= 1'b1;
                        r_state      <= StWait;
`ifdef DIHEDRAL_SCHED_WATCHDOG_EN
                        r_wd         <= '0;
`endif
                    end
                end
                StWait: begin
                    if (bus.core_valid) begin
                        for (int s = 0; s < 4; s++) r_force[s] <= bus.core_f[(3-s)*XyzW +: XyzW];
                        r_k        <= AtomA;
                        r_wb_valid <= 1'b1;
                        r_state    <= StWb;
                    end
`ifdef DIHEDRAL_SCHED_WATCHDOG_EN
                    else if (r_wd == WdW'(WD_LIMIT)) begin
                        r_err   <= 1'b1;
                        r_state <= StNext;
                    end else begin
                        r_wd <= r_wd + 1'b1;
                    end
`endif
                end
                StWb: begin
                    if (r_wb_valid && bus.wb_ready) begin
                        if (r_k == AtomD) begin
                            r_wb_valid <= 1'b0;
                            r_state    <= StNext;
                        end else begin
                            r_k <= r_k + 2'd1;
                        end
                    end
                end
                StNext: begin
                    r_tors_idx <= w_tors_next;
                    if (w_tors_next_ext == r_n) begin
                        r_state <= StDone;
                    end else begin
                        r_tt_rd   <= 1'b1;
                        r_tt_addr <= w_tors_next;
                        r_state   <= StTtRd;
                    end
                end
                StDone: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus.tt_rd      = r_tt_rd;
    assign bus.tt_addr    = r_tt_addr;
    assign bus.cm_rd      = r_cm_rd;
    assign bus.cm_addr    = r_cm_addr;
    assign bus.core_start = r_core_start;
    assign bus.wb_valid   = r_wb_valid;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.tors_idx   = r_tors_idx;

    assign bus.core_xa = r_coord[AtomA][0*CoordW +: CoordW];
    assign bus.core_ya = r_coord[AtomA][1*CoordW +: CoordW];
    assign bus.core_za = r_coord[AtomA][2*CoordW +: CoordW];
    assign bus.core_xb = r_coord[AtomB][0*CoordW +: CoordW];
    assign bus.core_yb = r_coord[AtomB][1*CoordW +: CoordW];
    assign bus.core_zb = r_coord[AtomB][2*CoordW +: CoordW];
    assign bus.core_xc = r_coord[AtomC][0*CoordW +: CoordW];
    assign bus.core_yc = r_coord[AtomC][1*CoordW +: CoordW];
    assign bus.core_zc = r_coord[AtomC][2*CoordW +: CoordW];
    assign bus.core_xd = r_coord[AtomD][0*CoordW +: CoordW];
    assign bus.core_yd = r_coord[AtomD][1*CoordW +: CoordW];
    assign bus.core_zd = r_coord[AtomD][2*CoordW +: CoordW];

    dihedral_wb_mux #(
        .IW (IW)
    ) u_wb_mux (
        .i_sel    (r_k),
        .i_atoms  (r_atoms),
        .i_forces (r_force),
        .o_atom   (bus.wb_atom),
        .o_fx     (bus.wb_fx),
        .o_fy     (bus.wb_fy),
        .o_fz     (bus.wb_fz)
    );

endmodule
